// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the core load/store bus, the DMA/program-loader bus and the data
// memory bus that meet at the data-memory arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/stall/memory)
//   master : the surrounding system's view (core, DMA engine and memory)
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    // core load/store path
    logic          core_req;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [BW-1:0] core_we;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    // DMA / program-loader path
    logic          dma_req;
    logic          dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [BW-1:0] dma_we;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    // synchronous data memory
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_addr, core_wdata, core_we,
        output core_stall, core_rvalid, core_rdata,
        input  dma_req, dma_lock, dma_addr, dma_wdata, dma_we,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output core_req, core_addr, core_wdata, core_we,
        input  core_stall, core_rvalid, core_rdata,
        output dma_req, dma_lock, dma_addr, dma_wdata, dma_we,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one synchronous data memory between the core load/store path and a
// DMA/program-loader port. The core wins by default; the DMA can hold the
// port for locked bursts of up to LOCK_MAX grants, and (when the starvation
// option is built in) is forced ahead of the core after MAX_WAIT refused
// cycles. Read data returns RD_LAT cycles after the access, in order, and is
// steered to its issuer by a small {valid, owner} tag pipeline.
//
// Build option: define DMEM_ARB_STARVE_EN to include the DMA starvation
// counter and its priority rule. Without it the DMA is served only on
// cycles without a core request or while it holds a lock.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int BW  = DW / 8;
    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DMA  = 2'd2
    } grant_e;

    grant_e             grant_s;
    logic               starved_s;
    logic               lock_full_s;
    logic [AW-1:0]      addr_s;
    logic [DW-1:0]      wdata_s;
    logic [BW-1:0]      we_s;
    logic               push_valid_s;
    logic               push_owner_s;

    logic               lock_r;
    logic [LCW-1:0]     lock_cnt_r;
    logic [RD_LAT-1:0]  tag_valid_r;
    logic [RD_LAT-1:0]  tag_owner_r;   // 1 = DMA issued the read

    // Reject parameter values the tag pipeline and counters are not built for.
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dmem_arbiter: RD_LAT must be 1..4");
    end
    if (MAX_WAIT < 1 || LOCK_MAX < 1) begin : g_bad_limits
        $error("dmem_arbiter: MAX_WAIT and LOCK_MAX must be at least 1");
    end
    if (DW % 8 != 0 || AW < 1) begin : g_bad_widths
        $error("dmem_arbiter: DW must be a multiple of 8 and AW positive");
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt_r;

    // Count consecutive cycles the DMA is refused; saturates at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (!bus.dma_req || (grant_s == GNT_DMA)) begin
            wait_cnt_r <= '0;
        end else if (wait_cnt_r != WCW'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign starved_s = (wait_cnt_r == WCW'(MAX_WAIT));
`else
    assign starved_s = 1'b0;
`endif

    // The lock budget is spent once the counter reaches LOCK_MAX.
    assign lock_full_s = (lock_cnt_r == LCW'(LOCK_MAX));

    // Fixed-priority grant: open lock burst, starved DMA, core, idle-cycle DMA.
    always_comb begin
        grant_s = GNT_NONE;
        if (!rst_n) begin
            grant_s = GNT_NONE;
        end else if (lock_r && bus.dma_req && !lock_full_s) begin
            grant_s = GNT_DMA;
        end else if (starved_s && bus.dma_req) begin
            grant_s = GNT_DMA;
        end else if (bus.core_req) begin
            grant_s = GNT_CORE;
        end else if (bus.dma_req) begin
            grant_s = GNT_DMA;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Steer the granted requester onto the memory bus; idle bus is all zero.
    always_comb begin
        addr_s  = '0;
        wdata_s = '0;
        we_s    = '0;
        case (grant_s)
            GNT_CORE: begin
                addr_s  = bus.core_addr;
                wdata_s = bus.core_wdata;
                we_s    = bus.core_we;
            end
            GNT_DMA: begin
                addr_s  = bus.dma_addr;
                wdata_s = bus.dma_wdata;
                we_s    = bus.dma_we;
            end
            default: begin
                addr_s  = '0;
                wdata_s = '0;
                we_s    = '0;
            end
        endcase
    end

    assign bus.mem_en     = (grant_s != GNT_NONE);
    assign bus.mem_addr   = addr_s;
    assign bus.mem_wdata  = wdata_s;
    assign bus.mem_we     = we_s;
    assign bus.dma_gnt    = (grant_s == GNT_DMA);
    assign bus.core_stall = rst_n & bus.core_req & (grant_s != GNT_CORE);

    // Only reads produce a return; remember who issued each one.
    assign push_valid_s = (grant_s != GNT_NONE) && (we_s == '0);
    assign push_owner_s = (grant_s == GNT_DMA);

    // Track the DMA lock: opened by a locked grant, closed when the DMA lets
    // go, drops its request, or has used its whole burst budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r     <= 1'b0;
            lock_cnt_r <= '0;
        end else if (!bus.dma_req || lock_full_s) begin
            lock_r     <= 1'b0;
            lock_cnt_r <= '0;
        end else if (grant_s == GNT_DMA) begin
            if (bus.dma_lock) begin
                lock_r     <= 1'b1;
                lock_cnt_r <= lock_cnt_r + LCW'(1);
            end else begin
                lock_r     <= 1'b0;
                lock_cnt_r <= '0;
            end
        end else begin
            lock_r     <= lock_r;
            lock_cnt_r <= lock_cnt_r;
        end
    end

    // Shift read tags along so each one surfaces exactly RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= '0;
            tag_owner_r <= '0;
        end else begin
            tag_valid_r[0] <= push_valid_s;
            tag_owner_r[0] <= push_owner_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_owner_r[i] <= tag_owner_r[i-1];
            end
        end
    end

    assign bus.core_rvalid = tag_valid_r[RD_LAT-1] & ~tag_owner_r[RD_LAT-1];
    assign bus.dma_rvalid  = tag_valid_r[RD_LAT-1] &  tag_owner_r[RD_LAT-1];
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.dma_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed scenarios followed by constrained-random traffic, all compared
// every cycle against a transaction-level model of the arbitration rules.
// Works with or without DMEM_ARB_STARVE_EN defined.
module tb_dmem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int BW       = 4;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;
    localparam int LOCK_MAX = 16;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    localparam int G_NONE = 0;
    localparam int G_CORE = 1;
    localparam int G_DMA  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic          rst_n;
        logic          creq;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic [BW-1:0] cwe;
        logic          dreq;
        logic          dlock;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic [BW-1:0] dwe;
    } stim_t;

    typedef struct {
        int due;
        bit dma;
    } tag_t;

    int   checks = 0;
    int   errors = 0;

    // model state: cycle number, refused-DMA streak, lock burst, pending reads
    int   cyc      = 0;
    int   waited   = 0;
    bit   locked   = 1'b0;
    int   lock_len = 0;
    tag_t pend[$];
    bit   last_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;
        s.creq  = 1'b0; s.caddr = '0; s.cwd = '0; s.cwe = '0;
        s.dreq  = 1'b0; s.dlock = 1'b0; s.daddr = '0; s.dwd = '0; s.dwe = '0;
        return s;
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare every output
    // against the model, then advance the model to the next cycle.
    task automatic step(input stim_t s);
        int            g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [BW-1:0] ewe;
        logic [DW-1:0] rd;
        bit            exp_cv;
        bit            exp_dv;
        tag_t          t;
        @(negedge clk);
        rst_n          = s.rst_n;
        bus.core_req   = s.creq;  bus.core_addr = s.caddr; bus.core_wdata = s.cwd; bus.core_we = s.cwe;
        bus.dma_req    = s.dreq;  bus.dma_lock  = s.dlock; bus.dma_addr   = s.daddr;
        bus.dma_wdata  = s.dwd;   bus.dma_we    = s.dwe;
        rd             = $urandom;
        bus.mem_rdata  = rd;
        #1;
        if (!s.rst_n)                                          g = G_NONE;
        else if (locked && s.dreq && lock_len < LOCK_MAX)      g = G_DMA;
        else if (STARVE && waited >= MAX_WAIT && s.dreq)       g = G_DMA;
        else if (s.creq)                                       g = G_CORE;
        else if (s.dreq)                                       g = G_DMA;
        else                                                   g = G_NONE;
        case (g)
            G_CORE:  begin ea = s.caddr; ewd = s.cwd; ewe = s.cwe; end
            G_DMA:   begin ea = s.daddr; ewd = s.dwd; ewe = s.dwe; end
            default: begin ea = '0;      ewd = '0;    ewe = '0;    end
        endcase
        exp_cv = 1'b0;
        exp_dv = 1'b0;
        if (s.rst_n && pend.size() > 0 && pend[0].due == cyc) begin
            exp_cv = !pend[0].dma;
            exp_dv = pend[0].dma;
        end
        chk("mem_en", bus.mem_en, g != G_NONE);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_we", bus.mem_we, ewe);
        if (g != G_NONE) chk("mem_wdata", bus.mem_wdata, ewd);
        chk("dma_gnt", bus.dma_gnt, g == G_DMA);
        chk("core_stall", bus.core_stall, s.rst_n && s.creq && g != G_CORE);
        chk("core_rvalid", bus.core_rvalid, exp_cv);
        chk("dma_rvalid", bus.dma_rvalid, exp_dv);
        if (exp_cv) chk("core_rdata", bus.core_rdata, rd);
        if (exp_dv) chk("dma_rdata", bus.dma_rdata, rd);
        last_stall = s.rst_n && s.creq && g != G_CORE;
        if (!s.rst_n) begin
            pend.delete();
            waited   = 0;
            locked   = 1'b0;
            lock_len = 0;
        end else begin
            if (exp_cv || exp_dv) void'(pend.pop_front());
            if (g != G_NONE && ewe == '0) begin
                t.due = cyc + RD_LAT;
                t.dma = (g == G_DMA);
                pend.push_back(t);
            end
            if (s.dreq && g != G_DMA) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
            else                      waited = 0;
            if (!s.dreq || lock_len == LOCK_MAX) begin
                locked = 1'b0; lock_len = 0;
            end else if (g == G_DMA) begin
                if (s.dlock) begin locked = 1'b1; lock_len++; end
                else         begin locked = 1'b0; lock_len = 0; end
            end
        end
        cyc++;
    endtask

    initial begin
        stim_t s;
        stim_t prev;
        int    first;
        bit    dreq_state;

        bus.core_req = 1'b0; bus.core_addr = '0; bus.core_wdata = '0; bus.core_we = '0;
        bus.dma_req  = 1'b0; bus.dma_lock  = 1'b0; bus.dma_addr = '0;
        bus.dma_wdata = '0;  bus.dma_we    = '0;  bus.mem_rdata = '0;

        // reset state, with requests present that must not leak through
        s = idle(); s.rst_n = 1'b0; s.creq = 1'b1; s.dreq = 1'b1;
        step(s);
        step(s);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_core_stall", bus.core_stall, 1'b0);
        chk("rst_lock", dut.lock_r, 1'b0);
        chk("rst_lock_cnt", dut.lock_cnt_r, 32'd0);
        step(idle());

        // core-only read of 0x100: same-cycle access, data RD_LAT cycles later
        s = idle(); s.creq = 1'b1; s.caddr = 32'h0000_0100;
        step(s);
        chk("core_rd_en", bus.mem_en, 1'b1);
        chk("core_rd_addr", bus.mem_addr, 32'h0000_0100);
        chk("core_rd_stall", bus.core_stall, 1'b0);
        step(idle());
        step(idle());
        chk("core_rd_rvalid", bus.core_rvalid, 1'b1);
        chk("core_rd_dma_rvalid", bus.dma_rvalid, 1'b0);

        // interleaved: core read then DMA read, returns in issue order
        s = idle(); s.creq = 1'b1; s.caddr = 32'h0000_0010;
        step(s);
        s = idle(); s.dreq = 1'b1; s.daddr = 32'h0000_0014;
        step(s);
        step(idle());
        chk("ilv_core_rvalid", bus.core_rvalid, 1'b1);
        chk("ilv_dma_rvalid0", bus.dma_rvalid, 1'b0);
        step(idle());
        chk("ilv_dma_rvalid", bus.dma_rvalid, 1'b1);
        chk("ilv_core_rvalid1", bus.core_rvalid, 1'b0);

        // DMA byte write: passes through, no read return follows
        s = idle(); s.dreq = 1'b1; s.daddr = 32'h0000_0020; s.dwe = 4'b0100; s.dwd = 32'h00AB_0000;
        step(s);
        chk("dma_wr_we", bus.mem_we, 4'b0100);
        chk("dma_wr_gnt", bus.dma_gnt, 1'b1);
        chk("dma_wr_addr", bus.mem_addr, 32'h0000_0020);
        for (int i = 0; i < 3; i++) begin
            step(idle());
            chk("dma_wr_no_rvalid", {bus.core_rvalid, bus.dma_rvalid}, 2'b00);
        end

        // contention: core always wins unless the DMA starves
        s = idle(); s.creq = 1'b1; s.caddr = 32'h0000_0200; s.dreq = 1'b1; s.daddr = 32'h0000_0300;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step(s);
            if (bus.dma_gnt && first == 0) begin
                first = i;
                chk("contend_stall", bus.core_stall, 1'b1);
            end
        end
        chk("contend_first_dma", first, STARVE ? 32'd9 : 32'd0);
        for (int i = 0; i < 3; i++) step(idle());

        // locked burst: opened while core idle, then held against the core
        s = idle(); s.dreq = 1'b1; s.dlock = 1'b1; s.daddr = 32'h0000_0040; s.dwe = 4'hF; s.dwd = 32'h1234_5678;
        step(s);
        chk("lock_open_gnt", bus.dma_gnt, 1'b1);
        s.creq = 1'b1; s.caddr = 32'h0000_0080;
        for (int i = 2; i <= 24; i++) begin
            step(s);
            if (i <= 16) chk("lock_gnt", {bus.dma_gnt, bus.core_stall}, 2'b11);
            if (i == 17 || i == 18) chk("lock_release_core", {bus.mem_en, bus.dma_gnt, bus.core_stall}, 3'b100);
        end
        for (int i = 0; i < 3; i++) step(idle());

        // reset while a core read is in flight: its return never appears
        s = idle(); s.creq = 1'b1; s.caddr = 32'h0000_0300; s.dreq = 1'b1; s.dlock = 1'b1;
        step(s);
        s = idle(); s.rst_n = 1'b0;
        step(s);
        chk("mid_rst_lock", dut.lock_r, 1'b0);
        chk("mid_rst_lock_cnt", dut.lock_cnt_r, 32'd0);
`ifdef DMEM_ARB_STARVE_EN
        chk("mid_rst_wait_cnt", dut.wait_cnt_r, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            step(idle());
            chk("mid_rst_no_rvalid", {bus.core_rvalid, bus.dma_rvalid}, 2'b00);
        end

        // randomized traffic; core holds its request while stalled
        dreq_state = 1'b1;
        prev = idle();
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            if ($urandom_range(0, 299) == 0) s.rst_n = 1'b0;
            if (last_stall) begin
                s.creq = prev.creq; s.caddr = prev.caddr; s.cwd = prev.cwd; s.cwe = prev.cwe;
            end else begin
                s.creq  = ($urandom_range(0, 9) < 8);
                s.caddr = $urandom & 32'h0000_0FFC;
                s.cwd   = $urandom;
                s.cwe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 7) == 0) dreq_state = ~dreq_state;
            s.dreq  = dreq_state;
            s.dlock = ($urandom_range(0, 1) == 0);
            s.daddr = $urandom & 32'h0000_0FFC;
            s.dwd   = $urandom;
            s.dwe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step(s);
            prev = s;
        end
        for (int i = 0; i < 4; i++) step(idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous data memory between two requesters: the core load/store path and a DMA/program-loader port.
- Sits between the core's store-formatting/load-extension logic and the data memory.
- Drives a stall back to the core when the core loses arbitration. Routes read data to whichever requester issued the read.
- Core has priority by default. DMA gets bounded-latency service through a starvation counter, and can hold the port for short locked bursts.

Parameters:
- AW, 32, address width
- DW, 32, data width; byte-enable width is DW/8
- RD_LAT, 1, memory read latency in cycles (1..4)
- MAX_WAIT, 8, DMA waiting cycles before it is forced ahead of the core
- LOCK_MAX, 16, maximum consecutive locked DMA grants

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core memory access this cycle (load or store)
- core_addr  in  AW  core byte address
- core_wdata  in  DW  core store data, already lane-aligned
- core_we  in  DW/8  core byte write enables (0 = read)
- core_stall  out  1  core must hold PC and request this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DW  read data for the core
- dma_req  in  1  DMA request
- dma_lock  in  1  keep the grant after this access
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_we  in  DW/8  DMA byte write enables
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DW  read data for DMA
- mem_en  out  1  memory access this cycle
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  DW/8  memory byte write enables
- mem_rdata  in  DW  memory read data, RD_LAT cycles after the access

Behaviour:
- State registers:
  - wait_cnt: 0..MAX_WAIT, saturating
  - lock_q: 1 bit
  - lock_cnt: 0..LOCK_MAX
  - tag pipeline: RD_LAT entries of {valid, owner}
- Reset: all state registers clear asynchronously. core_rvalid=0, dma_rvalid=0, dma_gnt=0, core_stall=0, mem_en=0 while rst_n=0.
- Grant decision is combinational each cycle, in priority order:
  1. lock_q & dma_req & lock_cnt<LOCK_MAX -> DMA
  2. wait_cnt==MAX_WAIT & dma_req -> DMA
  3. core_req -> CORE
  4. dma_req -> DMA
  5. otherwise none
- Outputs from the grant:
  - mem_en = any grant; mem_addr/mem_wdata/mem_we are muxed from the granted requester.
  - mem_we = 0 and mem_addr = 0 when there is no grant.
  - dma_gnt = grant==DMA.
  - core_stall = core_req & grant!=CORE.
- wait_cnt:
  - increments when dma_req & !dma_gnt;
  - clears on dma_gnt or when dma_req=0.
- Lock handling:
  - lock_q sets on a DMA grant with dma_lock=1.
  - lock_q clears on a DMA grant with dma_lock=0, on dma_req=0, or when lock_cnt reaches LOCK_MAX.
  - lock_cnt increments on each locked DMA grant and clears when lock_q clears.
  - When lock_cnt==LOCK_MAX with core_req=1, the core is granted that cycle; the lock then clears.
- Read return:
  - A granted access with we==0 pushes {1, owner} into the tag pipeline; writes push {0, -}.
  - RD_LAT cycles later, the matching rvalid pulses for one cycle.
  - mem_rdata goes to both rdata outputs unmodified; rvalid selects the consumer.
  - Returns are in order; at most one return per cycle.
- Simultaneous core read and DMA read cannot occur: at most one grant per cycle.
- Stores complete in the grant cycle; no response is generated.
- Reset mid-operation: outstanding tags are discarded and no rvalid fires afterwards.
- Core contract: while core_stall=1, the core holds core_req/addr/we/wdata stable. The arbiter does not check this.
- Latency:
  - Uncontended core read: rdata at cycle N+RD_LAT, no stall.
  - DMA worst case without lock: MAX_WAIT+1 cycles to grant.

Optional Feature:
- Macro: DMEM_ARB_STARVE_EN.
- Defined: starvation counter and priority rule 2 are active as described above.
- Undefined: wait_cnt is not implemented and rule 2 is removed; DMA is served only on cycles with core_req=0 or while locked. Ports are unchanged.

Test Plan:
- Core only: core_req read addr 0x100, RD_LAT=1 -> mem_en=1 same cycle, core_stall=0, core_rvalid=1 next cycle with mem_rdata; dma_rvalid=0.
- Contention: core_req and dma_req both held high -> core granted, wait_cnt counts 1..8, DMA granted on 9th cycle with core_stall=1 for that cycle only; with macro undefined, DMA never granted.
- Locked burst: dma_req=1, dma_lock=1 for 20 cycles, core_req=1 -> 16 consecutive dma_gnt, then 1 core grant, then lock_q=0 and core keeps priority.
- Interleaved reads: core read cycle 0, DMA read cycle 1 (core_req=0), RD_LAT=2 -> core_rvalid cycle 2, dma_rvalid cycle 3.
- DMA byte write dma_we=4'b0100 addr 0x20 -> mem_we=4'b0100, dma_gnt=1, no rvalid pulse.
- Reset mid-read: core read issued, rst_n low the next cycle with RD_LAT=2 -> no core_rvalid after reset; all counters read 0.
